serial_port_fifo_slave: RTL and testbench

//  Wishbone (pipelined) slave that bridges the system bus to a byte-wide UART transceiver through parametrised TX/RX FIFOs.

---
 rtl/serial_port_fifo_slave.sv | 150 +++++++++++++++
 tb/tb_serial_port_fifo_slave.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/serial_port_fifo_slave.sv
// serial_port_fifo_slave: pipelined Wishbone slave bridging the bus to a byte UART through TX/RX FIFOs
// with status, control and interrupt registers.
module serial_port_fifo_slave #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic        clk_bus,
    input  logic        rst_bus,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    input  logic [31:0] adr_i,
    input  logic        cyc_i,
    output logic        err_o,
    output logic        rty_o,
    input  logic [3:0]  sel_i,
    input  logic        stb_i,
    input  logic        we_i,
    output logic        stall_o,
    input  logic        uart_busy,
    input  logic        uart_ready,
    input  logic [7:0]  uart_dat_i,
    output logic        uart_start,
    output logic [7:0]  uart_dat_o,
    output logic        irq_o
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TCW = TAW + 1;
    localparam int RCW = RAW + 1;
    localparam logic [TCW-1:0] TX_MAX = TCW'(TX_DEPTH);
    localparam logic [RCW-1:0] RX_MAX = RCW'(RX_DEPTH);

    typedef enum logic [1:0] {IDLE, START, SEND} tx_state_t;

    logic [7:0]     tx_mem [TX_DEPTH];
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [TAW-1:0] tx_wp, tx_rp;
    logic [RAW-1:0] rx_wp, rx_rp;
    logic [TCW-1:0] tx_cnt;
    logic [RCW-1:0] rx_cnt;
    logic [2:0]     ctrl;
    logic           overrun;
    logic           ready_q, ready_qq;
    logic [7:0]     rx_dat_q;
    tx_state_t      state;

    logic        acc, is_data, is_stat, is_ctrl;
    logic        tx_req, tx_push, tx_pop, tx_err, tx_full, tx_empty;
    logic        rx_edge, rx_push, rx_pop, rx_ne, ovr_clr;
    logic [31:0] stat, rdata;
    logic        unused;

    function automatic logic [7:0] sat8(input logic [8:0] c);
        return c[8] ? 8'hff : c[7:0];
    endfunction

    assign rty_o    = 1'b0;
    assign stall_o  = 1'b0;
    assign unused   = ^{adr_i[31:4], adr_i[1:0], dat_i[31:8], sel_i[3:1]};

    assign acc      = cyc_i & stb_i;
    assign is_data  = adr_i[3:2] == 2'd0;
    assign is_stat  = adr_i[3:2] == 2'd1;
    assign is_ctrl  = adr_i[3:2] == 2'd2;
    assign tx_full  = tx_cnt == TX_MAX;
    assign tx_empty = tx_cnt == '0;
    assign rx_ne    = rx_cnt != '0;

    assign tx_pop   = state == IDLE && !tx_empty && !uart_busy;
    assign tx_req   = acc & we_i & is_data & sel_i[0];
    assign tx_push  = tx_req & (!tx_full | tx_pop);
    assign tx_err   = tx_req & !tx_push;

    // The RX byte is captured alongside ready so the pushed byte is the one present at the edge.
    assign rx_edge  = ready_q & ~ready_qq;
    assign rx_pop   = acc & ~we_i & is_data & rx_ne;
    assign rx_push  = rx_edge & (rx_cnt != RX_MAX | rx_pop);
    assign ovr_clr  = acc & we_i & is_stat & dat_i[3];

    assign stat = {8'b0, sat8(9'(tx_cnt)), sat8(9'(rx_cnt)), 4'b0, overrun, tx_empty, tx_full, rx_ne};

    always_comb
        rdata = is_data ? {23'b0, rx_ne, rx_ne ? rx_mem[rx_rp] : 8'h00} :
                is_stat ? stat :
                is_ctrl ? {29'b0, ctrl} : 32'b0;

    always_ff @(posedge clk_bus) begin
        if (tx_push) tx_mem[tx_wp] <= dat_i[7:0];
        if (rx_push) rx_mem[rx_wp] <= rx_dat_q;
    end

    always_ff @(posedge clk_bus) begin
        if (rst_bus) begin
            ack_o    <= 1'b0;
            err_o    <= 1'b0;
            dat_o    <= '0;
            tx_wp    <= '0;
            tx_rp    <= '0;
            tx_cnt   <= '0;
            rx_wp    <= '0;
            rx_rp    <= '0;
            rx_cnt   <= '0;
            ctrl     <= '0;
            overrun  <= 1'b0;
            irq_o    <= 1'b0;
            ready_q  <= uart_ready;
            ready_qq <= uart_ready;
            rx_dat_q <= '0;
        end else begin
            ack_o    <= acc & ~tx_err;
            err_o    <= tx_err;
            dat_o    <= (acc & ~we_i) ? rdata : '0;
            tx_wp    <= tx_push ? tx_wp + TAW'(1) : tx_wp;
            tx_rp    <= tx_pop ? tx_rp + TAW'(1) : tx_rp;
            tx_cnt   <= tx_cnt + TCW'(tx_push) - TCW'(tx_pop);
            rx_wp    <= rx_push ? rx_wp + RAW'(1) : rx_wp;
            rx_rp    <= rx_pop ? rx_rp + RAW'(1) : rx_rp;
            rx_cnt   <= rx_cnt + RCW'(rx_push) - RCW'(rx_pop);
            ctrl     <= (acc & we_i & is_ctrl & sel_i[0]) ? dat_i[2:0] : ctrl;
            overrun  <= (rx_edge & ~rx_push) ? 1'b1 : ovr_clr ? 1'b0 : overrun;
            irq_o    <= (ctrl[0] & rx_ne) | (ctrl[1] & tx_empty) | (ctrl[2] & overrun);
            ready_q  <= uart_ready;
            ready_qq <= ready_q;
            rx_dat_q <= uart_dat_i;
        end
    end

    always_ff @(posedge clk_bus) begin
        if (rst_bus) begin
            state      <= IDLE;
            uart_start <= 1'b0;
            uart_dat_o <= '0;
        end else begin
            case (state)
                IDLE: if (tx_pop) begin
                    uart_dat_o <= tx_mem[tx_rp];
                    uart_start <= 1'b1;
                    state      <= START;
                end
                START: if (uart_busy) begin
                    uart_start <= 1'b0;
                    state      <= SEND;
                end
                SEND: if (!uart_busy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_port_fifo_slave.sv
// tb_serial_port_fifo_slave: directed tests of the FIFO serial slave against a small transceiver model.
module tb_serial_port_fifo_slave;
    logic        clk_bus = 0, rst_bus = 1;
    logic [31:0] dat_i = 0, dat_o, adr_i = 0;
    logic        ack_o, err_o, rty_o, stall_o, cyc_i = 0, stb_i = 0, we_i = 0;
    logic [3:0]  sel_i = 0;
    logic        uart_busy, uart_ready = 0, uart_start, irq_o;
    logic [7:0]  uart_dat_i = 0, uart_dat_o;

    int cmp = 0, bad = 0;
    logic        ak, er;
    logic [31:0] q;
    logic        model_en = 0, hold_busy = 0, start_q = 0;
    logic [4:0]  bcnt = 0;
    int          start_cnt = 0;
    logic [7:0]  tx_log[$];

    serial_port_fifo_slave dut (
        .clk_bus(clk_bus), .rst_bus(rst_bus), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o),
        .adr_i(adr_i), .cyc_i(cyc_i), .err_o(err_o), .rty_o(rty_o), .sel_i(sel_i),
        .stb_i(stb_i), .we_i(we_i), .stall_o(stall_o), .uart_busy(uart_busy),
        .uart_ready(uart_ready), .uart_dat_i(uart_dat_i), .uart_start(uart_start),
        .uart_dat_o(uart_dat_o), .irq_o(irq_o)
    );

    always #5 clk_bus = ~clk_bus;

    // Transceiver model: goes busy for 10 cycles when a start is seen; logs every start request.
    assign uart_busy = hold_busy | (bcnt != 0);
    always @(posedge clk_bus) begin
        start_q <= uart_start;
        if (uart_start && !start_q) begin
            tx_log.push_back(uart_dat_o);
            start_cnt <= start_cnt + 1;
        end
        if (bcnt != 0) bcnt <= bcnt - 1;
        else if (uart_start && model_en) bcnt <= 10;
    end

    task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk_bus);
        cyc_i = 1; stb_i = 1; we_i = w; adr_i = {28'b0, a, 2'b0}; dat_i = d; sel_i = 4'hf;
        @(posedge clk_bus); #1;
        ak = ack_o; er = err_o; q = dat_o;
        cyc_i = 0; stb_i = 0; we_i = 0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(negedge clk_bus); uart_ready = 1; uart_dat_i = b;
        repeat (2) @(negedge clk_bus);
        uart_ready = 0;
        repeat (2) @(negedge clk_bus);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk_bus);
        @(negedge clk_bus); rst_bus = 0;
        @(posedge clk_bus); #1;
        cmp++; if ({ack_o, err_o, uart_start, irq_o} !== 4'b0) begin bad++; $display("FAIL reset_outs got %b want 0000", {ack_o, err_o, uart_start, irq_o}); end
        cmp++; if (uart_dat_o !== 8'h00) begin bad++; $display("FAIL reset_dat got %h want 00", uart_dat_o); end
        cmp++; if ({rty_o, stall_o} !== 2'b0) begin bad++; $display("FAIL tied_outs got %b want 00", {rty_o, stall_o}); end
        bus(0, 1, 0);
        cmp++; if (!ak || q !== 32'h4) begin bad++; $display("FAIL reset_stat got ack=%b %h want ack=1 00000004", ak, q); end
        bus(0, 3, 0);
        cmp++; if (!ak || q !== 32'h0) begin bad++; $display("FAIL reserved_read got ack=%b %h want ack=1 0", ak, q); end
    endtask

    task automatic test_tx_order;
        logic [7:0] exp [3] = '{8'h41, 8'h42, 8'h43};
        model_en = 1; tx_log.delete();
        for (int i = 0; i < 3; i++) begin
            bus(1, 0, {24'b0, exp[i]});
            cmp++; if (ak !== 1 || er !== 0) begin bad++; $display("FAIL tx_write_ack[%0d] got ack=%b err=%b want 1/0", i, ak, er); end
        end
        @(posedge clk_bus); #1;
        cmp++; if (ack_o !== 0) begin bad++; $display("FAIL ack_one_cycle got %b want 0", ack_o); end
        for (int i = 0; i < 300 && tx_log.size() < 3; i++) @(posedge clk_bus);
        repeat (30) @(posedge clk_bus);
        cmp++; if (tx_log.size() != 3) begin bad++; $display("FAIL tx_start_count got %0d want 3", tx_log.size()); end
        for (int i = 0; i < 3 && i < tx_log.size(); i++) begin
            cmp++; if (tx_log[i] !== exp[i]) begin bad++; $display("FAIL tx_byte[%0d] got %h want %h", i, tx_log[i], exp[i]); end
        end
    endtask

    task automatic test_tx_full;
        model_en = 0; hold_busy = 1;
        for (int i = 0; i < 17; i++) begin
            bus(1, 0, 32'h60 + i);
            cmp++;
            if (i < 16 && (ak !== 1 || er !== 0)) begin bad++; $display("FAIL tx_fill_ack[%0d] got ack=%b err=%b want 1/0", i, ak, er); end
            else if (i == 16 && (ak !== 0 || er !== 1)) begin bad++; $display("FAIL tx_overflow_err got ack=%b err=%b want 0/1", ak, er); end
        end
        bus(0, 1, 0);
        cmp++; if (q !== 32'h0010_0002) begin bad++; $display("FAIL tx_full_stat got %h want 00100002", q); end
        tx_log.delete(); model_en = 1; hold_busy = 0;
        for (int i = 0; i < 2000 && tx_log.size() < 16; i++) @(posedge clk_bus);
        repeat (30) @(posedge clk_bus);
        cmp++; if (tx_log.size() != 16) begin bad++; $display("FAIL tx_drain_count got %0d want 16", tx_log.size()); end
        for (int i = 0; i < 16 && i < tx_log.size(); i++) begin
            cmp++; if (tx_log[i] !== 8'(8'h60 + i)) begin bad++; $display("FAIL tx_drain_byte[%0d] got %h want %h", i, tx_log[i], 8'(8'h60 + i)); end
        end
        model_en = 0;
    endtask

    task automatic test_rx_overrun;
        for (int i = 0; i < 18; i++) rx_byte(8'hA0 + 8'(i));
        bus(0, 1, 0);
        cmp++; if (q !== 32'h0000_100D) begin bad++; $display("FAIL rx_overrun_stat got %h want 0000100d", q); end
        for (int i = 0; i < 17; i++) begin
            bus(0, 0, 0);
            cmp++;
            if (i < 16 && q !== (32'h1A0 + i)) begin bad++; $display("FAIL rx_read[%0d] got %h want %h", i, q, 32'h1A0 + i); end
            else if (i == 16 && (q !== 32'h0 || ak !== 1)) begin bad++; $display("FAIL rx_empty_read got ack=%b %h want ack=1 0", ak, q); end
        end
        bus(0, 1, 0);
        cmp++; if (q !== 32'h0000_000C) begin bad++; $display("FAIL rx_sticky_stat got %h want 0000000c", q); end
        bus(1, 1, 32'h8);
        bus(0, 1, 0);
        cmp++; if (q !== 32'h0000_0004) begin bad++; $display("FAIL rx_w1c_stat got %h want 00000004", q); end
    endtask

    task automatic test_full_pop_push;
        for (int i = 0; i < 16; i++) rx_byte(8'hC0 + 8'(i));
        @(negedge clk_bus); uart_ready = 1; uart_dat_i = 8'hEE;
        bus(0, 0, 0);
        cmp++; if (q !== 32'h1C0) begin bad++; $display("FAIL full_pop_read got %h want 000001c0", q); end
        @(negedge clk_bus); uart_ready = 0;
        repeat (2) @(negedge clk_bus);
        bus(0, 1, 0);
        cmp++; if (q !== 32'h0000_1005) begin bad++; $display("FAIL full_pop_stat got %h want 00001005", q); end
        for (int i = 0; i < 16; i++) begin
            bus(0, 0, 0);
            cmp++; if (q !== (i < 15 ? 32'h1C1 + i : 32'h1EE)) begin bad++; $display("FAIL full_pop_drain[%0d] got %h want %h", i, q, (i < 15 ? 32'h1C1 + i : 32'h1EE)); end
        end
    endtask

    task automatic test_irq;
        bus(1, 2, 32'h1);
        bus(0, 2, 0);
        cmp++; if (q !== 32'h1) begin bad++; $display("FAIL ctrl_read got %h want 1", q); end
        cmp++; if (irq_o !== 0) begin bad++; $display("FAIL irq_idle got %b want 0", irq_o); end
        @(negedge clk_bus); uart_ready = 1; uart_dat_i = 8'h5A;
        @(posedge clk_bus); #1;
        @(posedge clk_bus); #1;
        cmp++; if (irq_o !== 0) begin bad++; $display("FAIL irq_early got %b want 0", irq_o); end
        @(posedge clk_bus); #1;
        cmp++; if (irq_o !== 1) begin bad++; $display("FAIL irq_rise got %b want 1", irq_o); end
        uart_ready = 0;
        repeat (2) @(negedge clk_bus);
        bus(0, 0, 0);
        cmp++; if (q !== 32'h15A || irq_o !== 1) begin bad++; $display("FAIL irq_pop got %h irq=%b want 0000015a irq=1", q, irq_o); end
        @(posedge clk_bus); #1;
        cmp++; if (irq_o !== 0) begin bad++; $display("FAIL irq_fall got %b want 0", irq_o); end
        bus(1, 2, 32'hFFFF_FFFF);
        bus(0, 2, 0);
        cmp++; if (q !== 32'h7) begin bad++; $display("FAIL ctrl_mask got %h want 7", q); end
        @(posedge clk_bus); #1;
        cmp++; if (irq_o !== 1) begin bad++; $display("FAIL irq_tx_empty got %b want 1", irq_o); end
        bus(1, 2, 32'h0);
    endtask

    task automatic test_reset_start;
        int sc;
        model_en = 0; hold_busy = 0;
        for (int i = 0; i < 4; i++) bus(1, 0, 32'h30 + i);
        bus(0, 1, 0);
        cmp++; if (q !== 32'h0003_0000 || uart_start !== 1) begin bad++; $display("FAIL start_queued got %h start=%b want 00030000 start=1", q, uart_start); end
        sc = start_cnt;
        @(negedge clk_bus); rst_bus = 1;
        @(posedge clk_bus); #1;
        cmp++; if (uart_start !== 0) begin bad++; $display("FAIL rst_start got %b want 0", uart_start); end
        @(negedge clk_bus); rst_bus = 0;
        bus(0, 1, 0);
        cmp++; if (ak !== 1 || q !== 32'h4) begin bad++; $display("FAIL rst_stat got ack=%b %h want ack=1 00000004", ak, q); end
        repeat (20) @(posedge clk_bus);
        #1;
        cmp++; if (start_cnt != sc || uart_start !== 0) begin bad++; $display("FAIL rst_no_start got %0d starts want %0d", start_cnt, sc); end
    endtask

    initial begin
        test_reset;
        test_tx_order;
        test_tx_full;
        test_rx_overrun;
        test_full_pop_push;
        test_irq;
        test_reset_start;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
